exe_branch_resolver: RTL
========================

Name: exe_branch_resolver

Overview:
- Sits at the execute end of the ID/EXE pipeline register and consumes its jump-control fields: jump enable, jump-type LSB, 13-bit jump address and instruction-valid.
- Resolves each jump against the ALU zero flag.
- On a taken jump it issues a one-cycle PC redirect and drives flush signals back to the IF/ID and ID/EXE pipe registers, which squashes wrong-path instructions.
- Keeps a saturating count of taken jumps for debug.

Parameters:
ADDR_W, 13, width of jump target / PC address
FLUSH_CYCLES, 2, number of cycles the flush outputs stay asserted after a taken jump (legal range 1..15)
CNT_W, 16, width of taken-jump counter

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
ex_valid_in  input  1  EXE-stage instruction valid (pc_en from ID/EXE)
jenable_in  input  1  EXE instruction is a jump
jop_lsb_in  input  1  0 = unconditional jump, 1 = jump if zero_in
jaddr_in  input  ADDR_W  jump target from ID/EXE
zero_in  input  1  ALU zero flag for the current EXE instruction
stall_in  input  1  pipeline stall; EXE instruction held
pc_load_out  output  1  one-cycle PC redirect strobe
pc_target_out  output  ADDR_W  redirect target, valid when pc_load_out=1
flush_ifid_out  output  1  clear IF/ID register
flush_idexe_out  output  1  clear ID/EXE register
busy_out  output  1  resolver in FLUSH state
taken_cnt_out  output  CNT_W  saturating count of taken jumps

Behaviour:
- Reset (rst=1 at posedge), effective the next cycle:
  - State goes to IDLE and the flush counter goes to 0.
  - All outputs become 0, including pc_target_out and taken_cnt_out.
  - Reset mid-FLUSH aborts the flush immediately.
- Taken condition: take = ex_valid_in & jenable_in & (~jop_lsb_in | zero_in) & ~stall_in.
- FSM states are IDLE and FLUSH. All outputs are registered.
- IDLE:
  - If take is 1 at posedge N: in cycle N+1, pc_load_out=1, pc_target_out=jaddr_in sampled at N, and flush_ifid_out=flush_idexe_out=1.
  - On the same edge: busy_out=1, state=FLUSH, cnt=FLUSH_CYCLES-1, and taken_cnt_out increments.
  - If take is 0: outputs stay 0; pc_target_out holds its last value.
- FLUSH:
  - pc_load_out=0 after the first cycle, so it is exactly a 1-cycle pulse.
  - Flush outputs and busy_out stay 1.
  - Jump inputs are ignored; they come from wrong-path instructions.
  - With stall_in=0: if cnt==0, go to IDLE and drop flush and busy on that edge; otherwise cnt decrements.
  - With stall_in=1: cnt holds and outputs hold.
- Net result: with no stalls, the flush outputs are high for exactly FLUSH_CYCLES cycles, starting in the pc_load cycle.
- Back-to-back jumps: a taken jump on the same edge as the FLUSH->IDLE exit is ignored. The first jump evaluated is on the edge after busy_out falls.
- stall_in=1 in IDLE blocks evaluation, so a held jump is counted exactly once, on the first unstalled edge.
- Not-taken conditional jump (jop_lsb_in=1, zero_in=0): no pulse, no flush, counter unchanged.
- taken_cnt_out saturates at 2^CNT_W-1 and does not wrap.
- ex_valid_in=0 suppresses take regardless of the other inputs; this covers bubbles already inserted.

Test Plan:
- Reset: drive all inputs active with rst=1 for 3 cycles -> every output 0; after release, the first take produces taken_cnt_out=1.
- Unconditional jump: ex_valid=1, jenable=1, jop_lsb=0, jaddr=13'h0ABC for one cycle ->
  - next cycle: pc_load_out=1 and pc_target_out=0x0ABC;
  - flush outputs high for 2 cycles, then 0;
  - busy_out mirrors the flush outputs;
  - taken_cnt_out=1.
- Conditional jump: jop_lsb=1 with zero_in=0 -> no pc_load, no flush; the same with zero_in=1 and jaddr=0x1FFF -> pc_load with target 0x1FFF.
- Stall during flush: take, then stall_in=1 for 3 cycles in FLUSH -> flush outputs stay high 2+3=5 cycles total; pc_load pulses only once.
- Jumps during flush and back-to-back:
  - Drive take every cycle for 6 cycles with FLUSH_CYCLES=2 -> pc_load pulses on cycles 1 and 4.
  - taken_cnt_out=2; inputs during FLUSH are ignored.
- Saturation and mid-flush reset:
  - CNT_W=4: 17 taken jumps -> taken_cnt_out stays at 15.
  - Assert rst in the first FLUSH cycle -> flush and busy are 0 on the next cycle.

Source files
------------

// File: rtl/exe_branch_resolver.sv
// Execute-stage jump resolver: turns taken jumps into a one-cycle PC
// redirect plus a timed flush of the IF/ID and ID/EXE registers.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ex_valid_in       EXE instruction valid (pc_en from ID/EXE)
//   jenable_in        EXE instruction is a jump
//   jop_lsb_in        0 = unconditional, 1 = jump if zero_in
//   jaddr_in          jump target
//   zero_in           ALU zero flag
//   stall_in          pipeline stall, EXE instruction held
//   pc_load_out       one-cycle PC redirect strobe
//   pc_target_out     redirect target (held between jumps)
//   flush_ifid_out    clear IF/ID register
//   flush_idexe_out   clear ID/EXE register
//   busy_out          resolver is flushing
//   taken_cnt_out     saturating taken-jump count
module exe_branch_resolver #(
  parameter int ADDR_W       = 13,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_in,
  input  logic              jenable_in,
  input  logic              jop_lsb_in,
  input  logic [ADDR_W-1:0] jaddr_in,
  input  logic              zero_in,
  input  logic              stall_in,
  output logic              pc_load_out,
  output logic [ADDR_W-1:0] pc_target_out,
  output logic              flush_ifid_out,
  output logic              flush_idexe_out,
  output logic              busy_out,
  output logic [CNT_W-1:0]  taken_cnt_out
);

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } state_t;

  localparam logic [3:0] LP_CNT_INIT =
    4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_TAKEN_MAX = '1;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_pc_load;
  logic [ADDR_W-1:0]   r_target;
  logic                r_flush;
  logic                r_busy;
  logic [CNT_W-1:0]    r_taken;

  state_t              w_state_nxt;
  logic [3:0]          w_cnt_nxt;
  logic                w_pc_load_nxt;
  logic [ADDR_W-1:0]   w_target_nxt;
  logic                w_flush_nxt;
  logic                w_busy_nxt;
  logic [CNT_W-1:0]    w_taken_nxt;
  logic                w_take;

  // A stalled EXE instruction is not evaluated, so a held jump is
  // counted once, on its first unstalled edge.
  assign w_take = ex_valid_in & jenable_in &
                  (~jop_lsb_in | zero_in) & ~stall_in;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pc_load_nxt = 1'b0;
    w_target_nxt  = r_target;
    w_flush_nxt   = r_flush;
    w_busy_nxt    = r_busy;
    w_taken_nxt   = r_taken;
    unique case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_state_nxt   = S_FLUSH;
          w_cnt_nxt     = LP_CNT_INIT;
          w_pc_load_nxt = 1'b1;
          w_target_nxt  = jaddr_in;
          w_flush_nxt   = 1'b1;
          w_busy_nxt    = 1'b1;
          if (r_taken != LP_TAKEN_MAX)
            w_taken_nxt = r_taken + 1'b1;
        end
      end
      S_FLUSH: begin
        // Jump inputs here belong to wrong-path instructions.
        if (!stall_in) begin
          if (r_cnt == 4'd0) begin
            w_state_nxt = S_IDLE;
            w_flush_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_pc_load <= 1'b0;
      r_target  <= '0;
      r_flush   <= 1'b0;
      r_busy    <= 1'b0;
      r_taken   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pc_load <= w_pc_load_nxt;
      r_target  <= w_target_nxt;
      r_flush   <= w_flush_nxt;
      r_busy    <= w_busy_nxt;
      r_taken   <= w_taken_nxt;
    end
  end

  assign pc_load_out     = r_pc_load;
  assign pc_target_out   = r_target;
  assign flush_ifid_out  = r_flush;
  assign flush_idexe_out = r_flush;
  assign busy_out        = r_busy;
  assign taken_cnt_out   = r_taken;

endmodule
